// File: rtl/mha_pkg.sv
// Shared widths, tile typedefs, output FSM states and element narrowing for mha_out_collector.
// With MHA_OUT_SAT_EN defined, narrow_elem saturates to the output range; otherwise it wraps.
package mha_pkg;

  localparam int BLOCK_SIZE     = 2;
  localparam int WIDTH_ACC      = 32;
  localparam int WIDTH_OUT      = 16;
  localparam int FRAC_SHIFT     = 8;
  localparam int DEF_COL_Y      = 2;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int ROW_IDX_W      = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  typedef logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH_ACC-1:0] acc_tile_t;
  typedef logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH_OUT-1:0] out_tile_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } out_state_e;

`ifdef MHA_OUT_SAT_EN
  localparam logic signed [WIDTH_ACC-1:0] OUT_MAX = WIDTH_ACC'((2 ** (WIDTH_OUT - 1)) - 1);
  localparam logic signed [WIDTH_ACC-1:0] OUT_MIN = WIDTH_ACC'(-(2 ** (WIDTH_OUT - 1)));
`endif

  function automatic logic [WIDTH_OUT-1:0] narrow_elem(input logic signed [WIDTH_ACC-1:0] acc);
    logic signed [WIDTH_ACC-1:0] x;
    x = acc >>> FRAC_SHIFT;
`ifdef MHA_OUT_SAT_EN
    if (x > OUT_MAX) begin
      x = OUT_MAX;
    end else if (x < OUT_MIN) begin
      x = OUT_MIN;
    end
`endif
    return WIDTH_OUT'(x);
  endfunction

endpackage

// File: rtl/mha_tile_fifo.sv
// Synchronous tile FIFO, first-word fall-through read; one-cycle push-to-visible latency.
// A push while full is taken only if a pop happens in the same cycle; otherwise it is ignored.
module mha_tile_fifo
  import mha_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  out_tile_t                push_dat,
  input  logic                     pop,
  output out_tile_t                pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  out_tile_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: rtl/mha_out_collector.sv
// Captures accumulator tiles, narrows them (saturating when MHA_OUT_SAT_EN is defined) and streams rows;
// 3 cycles acc_valid->out_valid; out_ready stalls rows, full FIFO drops tiles and sets sticky overflow.
module mha_out_collector
  import mha_pkg::*;
#(
  parameter int  COL_Y      = DEF_COL_Y,
  parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int TW         = (COL_Y > 1) ? $clog2(COL_Y) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            acc_valid,
  input  acc_tile_t                       acc_data,
  output logic                            tile_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BLOCK_SIZE*WIDTH_OUT-1:0] out_data,
  output logic [ROW_IDX_W-1:0]            out_row_idx,
  output logic [TW-1:0]                   out_tile_idx,
  output logic                            out_last,
  output logic                            row_done,
  output logic                            overflow
);

  localparam int ROW_W  = BLOCK_SIZE * WIDTH_OUT;
  localparam int N_ELEM = BLOCK_SIZE * BLOCK_SIZE;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  out_tile_t            stage_d;
  out_tile_t            stage_q;
  logic                 stage_vld_q;
  out_tile_t            tile_q;
  out_state_e           state_q;
  logic [ROW_IDX_W-1:0] row_q;
  logic [TW-1:0]        tidx_q;
  logic                 row_done_q;
  logic                 overflow_q;
  logic                 tile_ready_q;

  out_tile_t            fifo_dat;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_pop;
  logic                 hs;
  logic                 last_row;
  logic                 last_tile;

  always_comb begin
    stage_d = '0;
    for (int e = 0; e < N_ELEM; e++) begin
      stage_d[e*WIDTH_OUT +: WIDTH_OUT] = narrow_elem(acc_data[e*WIDTH_ACC +: WIDTH_ACC]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_vld_q <= 1'b0;
      stage_q     <= '0;
    end else begin
      stage_vld_q <= acc_valid;
      if (acc_valid) begin
        stage_q <= stage_d;
      end
    end
  end

  mha_tile_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (stage_vld_q),
    .push_dat (stage_q),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign out_valid = (state_q == EMIT);
  assign hs        = out_valid && out_ready;
  assign last_row  = (row_q == ROW_IDX_W'(BLOCK_SIZE - 1));
  assign last_tile = (tidx_q == TW'(COL_Y - 1));
  // Pop on entry from IDLE, or right behind the last-row handshake so tiles stream without a bubble.
  assign fifo_pop  = !fifo_empty && ((state_q == IDLE) || (hs && last_row));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tile_q     <= '0;
      row_q      <= '0;
      tidx_q     <= '0;
      row_done_q <= 1'b0;
    end else begin
      row_done_q <= hs && last_row && last_tile;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            tile_q  <= fifo_dat;
            row_q   <= '0;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (hs) begin
            if (!last_row) begin
              row_q <= row_q + 1'b1;
            end else begin
              row_q  <= '0;
              tidx_q <= last_tile ? '0 : tidx_q + 1'b1;
              if (!fifo_empty) begin
                tile_q <= fifo_dat;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // tile_ready keeps one slot spare for the tile already sitting in the staging register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_ready_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      tile_ready_q <= (fifo_count < CW'(FIFO_DEPTH - 1)) || fifo_empty;
      if (stage_vld_q && fifo_full && !fifo_pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int r = 0; r < BLOCK_SIZE; r++) begin
      if (row_q == ROW_IDX_W'(r)) begin
        out_data = tile_q[r*ROW_W +: ROW_W];
      end
    end
  end

  assign out_row_idx  = row_q;
  assign out_tile_idx = tidx_q;
  assign out_last     = out_valid && last_row && last_tile;
  assign row_done     = row_done_q;
  assign overflow     = overflow_q;
  assign tile_ready   = tile_ready_q;

endmodule

// File: tb/tb_mha_out_collector.sv
// Directed bench for mha_out_collector with a row-beat scoreboard; honours MHA_OUT_SAT_EN.
module tb_mha_out_collector;

  typedef struct {
    logic [31:0] dat;
    logic        row;
    logic        tidx;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         acc_valid = 1'b0;
  logic [127:0] acc_data = '0;
  logic         tile_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic [0:0]   out_row_idx;
  logic [0:0]   out_tile_idx;
  logic         out_last;
  logic         row_done;
  logic         overflow;

  int    total = 0;
  int    bad   = 0;
  beat_t sb[$];
  logic  exp_tidx = 1'b0;

  always #5 clk = ~clk;

  mha_out_collector dut (
    .clk          (clk),
    .rst          (rst),
    .acc_valid    (acc_valid),
    .acc_data     (acc_data),
    .tile_ready   (tile_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row_idx  (out_row_idx),
    .out_tile_idx (out_tile_idx),
    .out_last     (out_last),
    .row_done     (row_done),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Independent narrowing reference: shift by 8, then wrap or clamp to 16 bits.
  function automatic logic [15:0] nar(input logic [31:0] a);
    int x;
    x = $signed(a) >>> 8;
`ifdef MHA_OUT_SAT_EN
    if (x > 32767) x = 32767;
    if (x < -32768) x = -32768;
`endif
    return x[15:0];
  endfunction

  task automatic push_rows(input logic [31:0] r0, input logic [31:0] r1);
    beat_t b;
    b.dat = r0; b.row = 1'b0; b.tidx = exp_tidx; b.last = 1'b0;
    sb.push_back(b);
    b.dat = r1; b.row = 1'b1; b.last = (exp_tidx == 1'b1);
    sb.push_back(b);
    exp_tidx = (exp_tidx == 1'b1) ? 1'b0 : 1'b1;
  endtask

  task automatic send_tile(input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3, input bit accepted);
    acc_data  = {e3, e2, e1, e0};
    acc_valid = 1'b1;
    if (accepted) push_rows({nar(e1), nar(e0)}, {nar(e3), nar(e2)});
    @(posedge clk); #1;
    acc_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    exp_tidx = 1'b0;
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_tile_ready"}, tile_ready, 1);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_row_done"}, row_done, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_idx"}, {out_tile_idx, out_row_idx}, 0);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, out_valid, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("beat_unexpected", out_data, 32'hxxxx_xxxx);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_dat", out_data, e.dat);
        chk("beat_row", out_row_idx, e.row);
        chk("beat_tile", out_tile_idx, e.tidx);
        chk("beat_last", out_last, e.last);
      end
    end
  end

  logic [31:0] held;

  initial begin
    do_reset("rst0");

    // T1: single tile, latency and row order
    out_ready = 1'b1;
    send_tile(32'h100, 32'h200, 32'h300, 32'h400, 1'b1);
    chk("t1_lat1", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_lat2", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_lat3", out_valid, 1);
    chk("t1_row0_dat", out_data, 32'h0002_0001);
    drain("t1_drain");

    // T2: two tiles back-to-back form one block-row
    do_reset("rst1");
    out_ready = 1'b1;
    send_tile(32'h1100, 32'h1200, 32'h1300, 32'h1400, 1'b1);
    send_tile(32'h2100, 32'h2200, 32'h2300, 32'h2400, 1'b1);
    wait_valid("t2_wait");
    for (int i = 0; i < 4; i++) begin
      chk("t2_nobubble", out_valid, 1);
      chk("t2_last", out_last, (i == 3));
      chk("t2_row_done_early", row_done, 0);
      @(posedge clk); #1;
    end
    chk("t2_row_done", row_done, 1);
    @(posedge clk); #1;
    chk("t2_row_done_pulse", row_done, 0);
    drain("t2_drain");

    // T3: backpressure mid-tile
    out_ready = 1'b0;
    send_tile(32'h3100, 32'h3200, 32'h3300, 32'h3400, 1'b1);
    wait_valid("t3_wait");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    held = out_data;
    chk("t3_row1", out_row_idx, 1);
    chk("t3_row1_dat", held, 32'h0034_0033);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t3_hold_dat", out_data, held);
      chk("t3_hold_row", out_row_idx, 1);
      chk("t3_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    drain("t3_drain");

    // T4: overflow; one tile parks in the emit register, FIFO_DEPTH more fill the FIFO, the next is dropped
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_tile(32'(i * 4 + 1) << 8, 32'(i * 4 + 2) << 8,
                32'(i * 4 + 3) << 8, 32'(i * 4 + 4) << 8, (i < 5));
    end
    @(posedge clk); #1;
    chk("t4_tile_ready", tile_ready, 0);
    chk("t4_overflow", overflow, 1);
    out_ready = 1'b1;
    drain("t4_drain");
    repeat (2) @(posedge clk);
    #1;
    chk("t4_idle", out_valid, 0);
    chk("t4_tile_ready_back", tile_ready, 1);
    chk("t4_overflow_sticky", overflow, 1);

    // T6: reset during row 1 of a tile
    out_ready = 1'b0;
    send_tile(32'h6100, 32'h6200, 32'h6300, 32'h6400, 1'b1);
    wait_valid("t6_wait");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t6_row1", out_row_idx, 1);
    do_reset("t6_rst");
    out_ready = 1'b1;
    send_tile(32'h7100, 32'h7200, 32'h7300, 32'h7400, 1'b1);
    wait_valid("t6_restart_wait");
    chk("t6_restart_idx", {out_tile_idx, out_row_idx}, 0);
    drain("t6_drain");

    // T5: narrowing of out-of-range values
    do_reset("rst2");
    out_ready = 1'b1;
    acc_data  = {32'hFFFF_FF00, 32'h0000_0100, 32'hFF00_0000, 32'h0100_0000};
    acc_valid = 1'b1;
`ifdef MHA_OUT_SAT_EN
    push_rows(32'h8000_7FFF, 32'hFFFF_0001);
`else
    push_rows(32'h0000_0000, 32'hFFFF_0001);
`endif
    @(posedge clk); #1;
    acc_valid = 1'b0;
    drain("t5_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
